// File: rtl/video_pkg.sv
// Shared definitions for the video path selector.
//   state_t     : selector FSM states (RUN, ARMED, BLANK)
//   BLANK_MAX   : largest supported post-switch blanking frame count
//   BLANK_W     : width of the blanking frame counter
//   sel_width() : minimum select width for a given number of paths
//   vs_active() : true when a VSYNC sample is at its active level
package video_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      ARMED = 2'd1,
      BLANK = 2'd2
   } state_t;

   localparam int BLANK_MAX = 15;
   localparam int BLANK_W   = $clog2(BLANK_MAX + 1);

   function automatic int sel_width(input int num_path);
      return (num_path <= 1) ? 1 : $clog2(num_path);
   endfunction

   function automatic logic vs_active(input logic vs, input logic pol);
      return vs == pol;
   endfunction

endpackage

// File: rtl/frame_sync_det.sv
// Frame boundary detector and switch watchdog for the active video path.
//   clk       : pixel clock
//   rst       : synchronous, active-low reset
//   vs        : VSYNC of the currently selected path
//   reload    : a path switch happens this cycle
//   reload_vs : VSYNC of the path being switched to
//   arm       : watchdog runs while high, held at zero otherwise
//   fb        : VSYNC went to its active level this cycle
//   timeout   : watchdog reached TIMEOUT-1 cycles while armed
module frame_sync_det
   import video_pkg::*;
#(
   parameter bit VS_POL  = 1'b1,
   parameter int TIMEOUT = 2000000
) (
   input  logic clk,
   input  logic rst,
   input  logic vs,
   input  logic reload,
   input  logic reload_vs,
   input  logic arm,
   output logic fb,
   output logic timeout
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic            vs_prev;
   logic [WD_W-1:0] wd_cnt;

   assign fb      = vs_active(vs, VS_POL) && !vs_active(vs_prev, VS_POL);
   assign timeout = arm && (wd_cnt == WD_W'(TIMEOUT - 1));

   // NOTE: registers are written with <= so every flop samples the values
   // from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vs_prev <= ~VS_POL;
         wd_cnt  <= '0;
      end else begin
         // On a switch, start edge detection from the new path's level so
         // an already-active VSYNC there is not mistaken for a new frame.
         vs_prev <= reload ? reload_vs : vs;
         wd_cnt  <= arm ? wd_cnt + 1'b1 : '0;
      end
   end

endmodule

// File: rtl/video_path_mux.sv
// Frame-synchronous selector between parallel video processing paths.
// Switches only on a VSYNC edge of the current path (or on watchdog expiry),
// then optionally blanks RGB for BLANK_FRAMES frames of the new path.
//   clk, rst                    : pixel clock, synchronous active-low reset
//   sel_req                     : requested path (>= NUM_PATH means none)
//   path_red/green/blue         : packed per-path colour, path i at [i*DATA_W +: DATA_W]
//   path_dv/hs/vs               : per-path data valid and syncs
//   tx_red/green/blue/dv/hs/vs  : registered output of the selected path
//   cur_sel                     : currently active path
//   switching                   : high while ARMED or BLANK
//   frame_cnt                   : frame boundaries seen on the active path
module video_path_mux
   import video_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int NUM_PATH     = 4,
   parameter int SEL_W        = 2,
   parameter int DEFAULT_SEL  = 0,
   parameter int BLANK_FRAMES = 1,
   parameter bit VS_POL       = 1'b1,
   parameter int TIMEOUT      = 2000000,
   parameter int FCNT_W       = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SEL_W-1:0]             sel_req,
   input  logic [NUM_PATH*DATA_W-1:0]   path_red,
   input  logic [NUM_PATH*DATA_W-1:0]   path_green,
   input  logic [NUM_PATH*DATA_W-1:0]   path_blue,
   input  logic [NUM_PATH-1:0]          path_dv,
   input  logic [NUM_PATH-1:0]          path_hs,
   input  logic [NUM_PATH-1:0]          path_vs,
   output logic [DATA_W-1:0]            tx_red,
   output logic [DATA_W-1:0]            tx_green,
   output logic [DATA_W-1:0]            tx_blue,
   output logic                         tx_dv,
   output logic                         tx_hs,
   output logic                         tx_vs,
   output logic [SEL_W-1:0]             cur_sel,
   output logic                         switching,
   output logic [FCNT_W-1:0]            frame_cnt
);

   // Every select code gets a slot; codes beyond NUM_PATH read as zero so
   // the muxes are fully defined for any SEL_W.
   localparam int NUM_SLOT = 1 << SEL_W;
   localparam logic [SEL_W:0] NUM_PATH_V = (SEL_W + 1)'(NUM_PATH);

   logic [DATA_W-1:0] red_slot   [NUM_SLOT];
   logic [DATA_W-1:0] green_slot [NUM_SLOT];
   logic [DATA_W-1:0] blue_slot  [NUM_SLOT];
   logic [NUM_SLOT-1:0] dv_slot, hs_slot, vs_slot;

   for (genvar i = 0; i < NUM_SLOT; i++) begin : g_slot
      if (i < NUM_PATH) begin : g_used
         assign red_slot[i]   = path_red[i*DATA_W +: DATA_W];
         assign green_slot[i] = path_green[i*DATA_W +: DATA_W];
         assign blue_slot[i]  = path_blue[i*DATA_W +: DATA_W];
         assign dv_slot[i]    = path_dv[i];
         assign hs_slot[i]    = path_hs[i];
         assign vs_slot[i]    = path_vs[i];
      end else begin : g_empty
         assign red_slot[i]   = '0;
         assign green_slot[i] = '0;
         assign blue_slot[i]  = '0;
         assign dv_slot[i]    = 1'b0;
         assign hs_slot[i]    = 1'b0;
         assign vs_slot[i]    = 1'b0;
      end
   end

   state_t             state;
   logic [BLANK_W-1:0] blank_cnt;
   logic               req_valid;
   logic               req_other;
   logic               fb;
   logic               timeout;
   logic               do_switch;

   assign req_valid = {1'b0, sel_req} < NUM_PATH_V;
   assign req_other = req_valid && (sel_req != cur_sel);
   // A switch needs a still-valid, different request; a request withdrawn
   // in the same cycle as fb wins and no switch happens.
   assign do_switch = (state == ARMED) && req_other && (fb || timeout);

   frame_sync_det #(
      .VS_POL  (VS_POL),
      .TIMEOUT (TIMEOUT)
   ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .vs        (vs_slot[cur_sel]),
      .reload    (do_switch),
      .reload_vs (vs_slot[sel_req]),
      .arm       (state == ARMED),
      .fb        (fb),
      .timeout   (timeout)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         cur_sel   <= SEL_W'(DEFAULT_SEL);
         blank_cnt <= '0;
         frame_cnt <= '0;
         switching <= 1'b0;
         tx_red    <= '0;
         tx_green  <= '0;
         tx_blue   <= '0;
         tx_dv     <= 1'b0;
         tx_hs     <= 1'b0;
         tx_vs     <= 1'b0;
      end else begin
         // Syncs and dv always follow the active path; only colour blanks.
         tx_dv <= dv_slot[cur_sel];
         tx_hs <= hs_slot[cur_sel];
         tx_vs <= vs_slot[cur_sel];
         if (state == BLANK) begin
            tx_red   <= '0;
            tx_green <= '0;
            tx_blue  <= '0;
         end else begin
            tx_red   <= red_slot[cur_sel];
            tx_green <= green_slot[cur_sel];
            tx_blue  <= blue_slot[cur_sel];
         end

         if (fb) frame_cnt <= frame_cnt + 1'b1;

         // NOTE: the default arm recovers from an unused state encoding and
         // keeps every branch fully specified.
         case (state)
            RUN: begin
               if (req_other) begin
                  state     <= ARMED;
                  switching <= 1'b1;
               end
            end
            ARMED: begin
               if (!req_other) begin
                  state     <= RUN;
                  switching <= 1'b0;
               end else if (do_switch) begin
                  cur_sel   <= sel_req;
                  blank_cnt <= BLANK_W'(BLANK_FRAMES);
                  if (BLANK_FRAMES == 0) begin
                     state     <= RUN;
                     switching <= 1'b0;
                  end else begin
                     state <= BLANK;
                  end
               end
            end
            BLANK: begin
               // Requests are ignored here; RUN re-arms if still pending.
               if (fb) begin
                  if (blank_cnt <= BLANK_W'(1)) begin
                     blank_cnt <= '0;
                     state     <= RUN;
                     switching <= 1'b0;
                  end else begin
                     blank_cnt <= blank_cnt - 1'b1;
                  end
               end
            end
            default: begin
               state     <= RUN;
               switching <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_path_mux.sv
// Directed bench for video_path_mux. The driver pushes hand-computed
// expectations tagged with a cycle number; a monitor on the falling edge
// pops and compares them against the DUT outputs.
module tb_video_path_mux;

   localparam int DATA_W       = 8;
   localparam int NUM_PATH     = 4;
   localparam int SEL_W        = 3;
   localparam int FCNT_W       = 16;
   localparam int TIMEOUT      = 100;
   localparam int BLANK_FRAMES = 1;

   typedef enum int {F_RGB, F_SYNC, F_SEL, F_SW, F_FCNT} fld_e;

   typedef struct {
      int          cyc;
      string       name;
      fld_e        fld;
      logic [31:0] val;
   } exp_t;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [SEL_W-1:0]           sel_req;
   logic [NUM_PATH*DATA_W-1:0] path_red, path_green, path_blue;
   logic [NUM_PATH-1:0]        path_dv, path_hs, path_vs;
   logic [DATA_W-1:0]          tx_red, tx_green, tx_blue;
   logic                       tx_dv, tx_hs, tx_vs;
   logic [SEL_W-1:0]           cur_sel;
   logic                       switching;
   logic [FCNT_W-1:0]          frame_cnt;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   video_path_mux #(
      .DATA_W       (DATA_W),
      .NUM_PATH     (NUM_PATH),
      .SEL_W        (SEL_W),
      .DEFAULT_SEL  (0),
      .BLANK_FRAMES (BLANK_FRAMES),
      .VS_POL       (1'b1),
      .TIMEOUT      (TIMEOUT),
      .FCNT_W       (FCNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sel_req    (sel_req),
      .path_red   (path_red),
      .path_green (path_green),
      .path_blue  (path_blue),
      .path_dv    (path_dv),
      .path_hs    (path_hs),
      .path_vs    (path_vs),
      .tx_red     (tx_red),
      .tx_green   (tx_green),
      .tx_blue    (tx_blue),
      .tx_dv      (tx_dv),
      .tx_hs      (tx_hs),
      .tx_vs      (tx_vs),
      .cur_sel    (cur_sel),
      .switching  (switching),
      .frame_cnt  (frame_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   function automatic logic [31:0] actual(input fld_e f);
      case (f)
         F_RGB:   return {8'h0, tx_red, tx_green, tx_blue};
         F_SYNC:  return {29'h0, tx_dv, tx_hs, tx_vs};
         F_SEL:   return {29'h0, cur_sel};
         F_SW:    return {31'h0, switching};
         default: return {16'h0, frame_cnt};
      endcase
   endfunction

   // Monitor: compares every expectation due in the current cycle.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.cyc < cyc) begin
            n_total++;
            $display("FAIL %s: expectation for cycle %0d missed", e.name, e.cyc);
         end else begin
            check(e.name, actual(e.fld), e.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_all(input string name, input logic [23:0] rgb, input logic [2:0] sync,
                          input int sel, input logic sw, input int fcnt);
      exp_q.push_back('{cyc, {name, "_rgb"},  F_RGB,  {8'h0, rgb}});
      exp_q.push_back('{cyc, {name, "_sync"}, F_SYNC, {29'h0, sync}});
      exp_q.push_back('{cyc, {name, "_sel"},  F_SEL,  32'(sel)});
      exp_q.push_back('{cyc, {name, "_sw"},   F_SW,   {31'h0, sw}});
      exp_q.push_back('{cyc, {name, "_fcnt"}, F_FCNT, 32'(fcnt)});
   endtask

   // Path colours: p0 112233, p1 445566, p2 778899, p3 AABBCC.
   // Syncs {dv,hs}: p0 10, p1 00, p2 01, p3 11.
   initial begin
      path_red   = {8'hAA, 8'h77, 8'h44, 8'h11};
      path_green = {8'hBB, 8'h88, 8'h55, 8'h22};
      path_blue  = {8'hCC, 8'h99, 8'h66, 8'h33};
      path_dv    = 4'b1001;
      path_hs    = 4'b1100;
      path_vs    = 4'b0000;
      sel_req    = '0;
      rst        = 1'b0;

      // Reset and release
      step(); step(); exp_all("rst", 24'h0, 3'b000, 0, 1'b0, 0);
      rst = 1'b1;
      step(); exp_all("t1", 24'h112233, 3'b100, 0, 1'b0, 0);

      // Request withdrawn before any VS edge
      sel_req = 3'd1; step(); exp_all("t3_arm",  24'h112233, 3'b100, 0, 1'b1, 0);
      sel_req = 3'd0; step(); exp_all("t3_back", 24'h112233, 3'b100, 0, 1'b0, 0);
      step();                 exp_all("t3_idle", 24'h112233, 3'b100, 0, 1'b0, 0);

      // Withdrawal coinciding with a frame boundary: no switch, frame counted
      sel_req = 3'd1; step(); exp_all("t3b_arm", 24'h112233, 3'b100, 0, 1'b1, 0);
      sel_req = 3'd0; path_vs[0] = 1'b1;
      step(); exp_all("t3b_fb", 24'h112233, 3'b101, 0, 1'b0, 1);
      path_vs[0] = 1'b0;
      step(); exp_all("t3b_idle", 24'h112233, 3'b100, 0, 1'b0, 1);

      // Out-of-range requests are no request
      sel_req = 3'd5; step(); exp_all("t5_inv", 24'h112233, 3'b100, 0, 1'b0, 1);
      path_vs[0] = 1'b1;
      step(); exp_all("t5_fb", 24'h112233, 3'b101, 0, 1'b0, 2);
      path_vs[0] = 1'b0; sel_req = 3'd1;
      step(); exp_all("t5_arm", 24'h112233, 3'b100, 0, 1'b1, 2);
      sel_req = 3'd6;
      step(); exp_all("t5_disarm", 24'h112233, 3'b100, 0, 1'b0, 2);

      // Switch 0 -> 2 on path0 VS edge, one blank frame
      sel_req = 3'd2; step(); exp_all("t2_arm", 24'h112233, 3'b100, 0, 1'b1, 2);
      step(); step();         exp_all("t2_hold", 24'h112233, 3'b100, 0, 1'b1, 2);
      path_vs[0] = 1'b1;
      step(); exp_all("t2_sw", 24'h112233, 3'b101, 2, 1'b1, 3);
      path_vs[0] = 1'b0;
      step(); exp_all("t2_blank",  24'h0, 3'b010, 2, 1'b1, 3);
      step(); exp_all("t2_blank2", 24'h0, 3'b010, 2, 1'b1, 3);
      path_vs[2] = 1'b1;
      step(); exp_all("t2_end", 24'h0, 3'b011, 2, 1'b0, 4);
      step(); exp_all("t2_run", 24'h778899, 3'b011, 2, 1'b0, 4);
      path_vs[2] = 1'b0;
      step(); exp_all("t2_run2", 24'h778899, 3'b010, 2, 1'b0, 4);

      // Reset back to path 0
      rst = 1'b0; step(); exp_all("rst2", 24'h0, 3'b000, 0, 1'b0, 0);
      rst = 1'b1; sel_req = 3'd0;
      step(); exp_all("rst2_rel", 24'h112233, 3'b100, 0, 1'b0, 0);

      // Watchdog: path0 VS stays low, switch exactly TIMEOUT cycles after arming
      sel_req = 3'd3; step(); exp_all("t4_arm", 24'h112233, 3'b100, 0, 1'b1, 0);
      repeat (TIMEOUT - 1) step();
      exp_all("t4_pre", 24'h112233, 3'b100, 0, 1'b1, 0);
      step(); exp_all("t4_sw",    24'h112233, 3'b100, 3, 1'b1, 0);
      step(); exp_all("t4_blank", 24'h0, 3'b110, 3, 1'b1, 0);
      path_vs[3] = 1'b1;
      step(); exp_all("t4_end", 24'h0, 3'b111, 3, 1'b0, 1);
      step(); exp_all("t4_run", 24'hAABBCC, 3'b111, 3, 1'b0, 1);
      path_vs[3] = 1'b0;
      step();

      // Reset in the middle of BLANK; requests during BLANK are ignored
      sel_req = 3'd2; step(); exp_all("t6_arm", 24'hAABBCC, 3'b110, 3, 1'b1, 1);
      path_vs[3] = 1'b1;
      step(); exp_all("t6_sw", 24'hAABBCC, 3'b111, 2, 1'b1, 2);
      path_vs[3] = 1'b0; sel_req = 3'd1;
      step(); exp_all("t6_blank",  24'h0, 3'b010, 2, 1'b1, 2);
      step(); exp_all("t6_ignore", 24'h0, 3'b010, 2, 1'b1, 2);
      rst = 1'b0;
      step(); exp_all("t6_rst", 24'h0, 3'b000, 0, 1'b0, 0);
      rst = 1'b1; sel_req = 3'd0;
      step(); exp_all("t6_rel", 24'h112233, 3'b100, 0, 1'b0, 0);

      step(); step();
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_total++;
         $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.cyc);
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
